// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: serializes a WIDTH-bit word onto sout with frame strobes.
// Latency: first bit on sout the cycle after the accepting edge, then one bit per cycle.
// Backpressure: load_ready is low while shifting (except the last bit when GAP=0) and during the idle gap.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]    bit_cnt, bit_nxt;
    logic [3:0]       gap_cnt, gap_nxt;
    logic             sout_nxt, sout_valid_nxt, frame_start_nxt, frame_end_nxt;
    logic             accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    assign load_ready = (state == ST_IDLE) ||
                        ((GAP == 0) && (state == ST_SHIFT) && (bit_cnt == BIT_LAST));
    assign accept     = load_valid && load_ready;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                    shift_nxt = load_data;
                    bit_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_nxt = '0;
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = 4'd0;
                    end else if (accept) begin
                        // seamless reload: next frame's first bit follows with no bubble
                        shift_nxt = load_data;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    shift_nxt = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_reg[WIDTH-1:1]};
                    bit_nxt   = bit_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = 4'd0;
                end else begin
                    gap_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // outputs are registered, so decode them from the next-state values
        sout_valid_nxt  = (state_nxt == ST_SHIFT);
        sout_nxt        = sout_valid_nxt && head_bit(shift_nxt);
        frame_start_nxt = sout_valid_nxt && (bit_nxt == '0);
        frame_end_nxt   = sout_valid_nxt && (bit_nxt == BIT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= 4'd0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            bit_cnt     <= bit_nxt;
            gap_cnt     <= gap_nxt;
            sout        <= sout_nxt;
            sout_valid  <= sout_valid_nxt;
            frame_start <= frame_start_nxt;
            frame_end   <= frame_end_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (default, LSB-first, GAP=2) checked by a timestamped scoreboard.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv [3];
    logic [3:0] ld [3];
    logic       lr [3];
    logic       so [3];
    logic       sv [3];
    logic       fs [3];
    logic       fe [3];
    logic       bz [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   dut;
        int   cyc;
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .sout(so[0]), .sout_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .sout(so[1]), .sout_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
        .sout(so[2]), .sout_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

    task automatic chk(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b required %b (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_bit(input int d, input int c, input logic b, input logic f_s, input logic f_e);
        exp_t x;
        x.dut = d; x.cyc = c; x.b = b; x.fs = f_s; x.fe = f_e;
        q.push_back(x);
    endtask

    // seq[3] is the first bit expected on the wire
    task automatic push_frame(input int d, input int base, input logic [3:0] seq);
        for (int i = 0; i < 4; i++)
            push_bit(d, base + i, seq[3-i], i == 0, i == 3);
    endtask

    // Two words with load_valid held high; the second is expected to be accepted k2 edges after the first.
    task automatic b2b(input int d, input logic [3:0] w1, input logic [3:0] w2,
                       input logic [3:0] s1, input logic [3:0] s2, input int k2);
        int base;
        @(negedge clk);
        base  = cyc + 1;
        lv[d] = 1'b1;
        ld[d] = w1;
        push_frame(d, base, s1);
        push_frame(d, base + k2, s2);
        @(negedge clk);
        ld[d] = w2;
        repeat (k2) @(negedge clk);
        lv[d] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: every presented bit must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (sv[d]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit dut%0d cyc %0d sout %b required no output", d, cyc, so[d]);
                end else begin
                    e = q.pop_front();
                    if (e.dut != d || e.cyc != cyc || e.b !== so[d] || e.fs !== fs[d] || e.fe !== fe[d]) begin
                        errors++;
                        $display("FAIL frame_bit got dut%0d cyc %0d sout %b fs %b fe %b required dut%0d cyc %0d sout %b fs %b fe %b",
                                 d, cyc, so[d], fs[d], fe[d], e.dut, e.cyc, e.b, e.fs, e.fe);
                    end
                end
            end else if (so[d] || fs[d] || fe[d]) begin
                checks++;
                errors++;
                $display("FAIL idle_outputs dut%0d cyc %0d sout %b fs %b fe %b required 0 0 0", d, cyc, so[d], fs[d], fe[d]);
            end
        end
    end

    initial begin
        int base;
        for (int d = 0; d < 3; d++) begin
            lv[d] = 1'b0;
            ld[d] = 4'h0;
        end

        // reset state
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_sout", so[d], 1'b0);
            chk("rst_sout_valid", sv[d], 1'b0);
            chk("rst_busy", bz[d], 1'b0);
            chk("rst_load_ready", lr[d], 1'b1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, MSB first
        @(negedge clk);
        base  = cyc + 1;
        lv[0] = 1'b1;
        ld[0] = 4'b1011;
        push_frame(0, base, 4'b1011);
        @(negedge clk);
        lv[0] = 1'b0;
        chk("s1_ready_t1", lr[0], 1'b0);
        chk("s1_busy_t1", bz[0], 1'b1);
        @(negedge clk); chk("s1_ready_t2", lr[0], 1'b0);
        @(negedge clk); chk("s1_ready_t3", lr[0], 1'b0);
        @(negedge clk); chk("s1_ready_t4", lr[0], 1'b1);
        @(negedge clk);
        chk("s1_busy_t5", bz[0], 1'b0);
        chk("s1_ready_t5", lr[0], 1'b1);
        repeat (2) @(negedge clk);

        // back-to-back frames, no bubble
        b2b(0, 4'b1011, 4'b0110, 4'b1011, 4'b0110, 4);

        // LSB first: 1011 goes out as 1,1,0,1
        @(negedge clk);
        base  = cyc + 1;
        lv[1] = 1'b1;
        ld[1] = 4'b1011;
        push_frame(1, base, 4'b1101);
        @(negedge clk);
        lv[1] = 1'b0;
        repeat (5) @(negedge clk);

        // GAP=2: second word waits through two idle cycles
        @(negedge clk);
        base  = cyc + 1;
        lv[2] = 1'b1;
        ld[2] = 4'b1011;
        push_frame(2, base, 4'b1011);
        push_frame(2, base + 7, 4'b0110);
        @(negedge clk);
        ld[2] = 4'b0110;
        chk("s4_ready_t1", lr[2], 1'b0);
        repeat (3) @(negedge clk);
        chk("s4_ready_t4", lr[2], 1'b0);
        @(negedge clk);
        chk("s4_ready_t5", lr[2], 1'b0);
        chk("s4_busy_t5", bz[2], 1'b1);
        @(negedge clk);
        chk("s4_ready_t6", lr[2], 1'b0);
        @(negedge clk);
        chk("s4_ready_t7", lr[2], 1'b1);
        chk("s4_busy_t7", bz[2], 1'b0);
        @(negedge clk);
        lv[2] = 1'b0;
        chk("s4_busy_t8", bz[2], 1'b1);
        repeat (8) @(negedge clk);

        // reset during the second bit aborts the frame
        @(negedge clk);
        base  = cyc + 1;
        lv[0] = 1'b1;
        ld[0] = 4'b1011;
        push_bit(0, base, 1'b1, 1'b1, 1'b0);
        push_bit(0, base + 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        lv[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("s5_sout", so[0], 1'b0);
        chk("s5_sout_valid", sv[0], 1'b0);
        chk("s5_frame_end", fe[0], 1'b0);
        chk("s5_busy", bz[0], 1'b0);
        chk("s5_load_ready", lr[0], 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base  = cyc + 1;
        lv[0] = 1'b1;
        ld[0] = 4'b0001;
        push_frame(0, base, 4'b0001);
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (5) @(negedge clk);

        // load_data changes while busy must not disturb the frame in flight
        b2b(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the team's 4-bit serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock on sout. sout connects straight to the downstream register's din.
- Emits frame strobes so the consumer knows when a full word has been shifted in.
- Supports back-to-back words and an optional programmable idle gap between frames.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- GAP, 0, idle cycles inserted after each frame before the next load is accepted; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  upstream presents a word on load_data.
- load_data  input  WIDTH  word to serialize; sampled only on handshake.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit; feeds downstream din.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high on the first bit of a frame.
- frame_end  output  1  high on the last bit of a frame.
- busy  output  1  high in SHIFT or GAP state.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately):
  - state=IDLE; shift_reg=0; bit_cnt=0; gap_cnt=0.
  - sout=0, sout_valid=0, frame_start=0, frame_end=0, busy=0, load_ready=1.
- Reset release: the block leaves reset on the first rising edge with rst=1. No handshake is accepted on that edge unless load_valid is already high.
- Handshake:
  - A word is accepted on a rising edge when load_valid=1 and load_ready=1.
  - load_data is captured into shift_reg on that edge.
  - load_data is ignored at all other times.
  - load_valid may be held high while load_ready=0; the word is accepted on the first edge with load_ready=1.
- Latency: the first bit appears on sout in the cycle immediately after the accepting edge. sout and all strobes are registered outputs.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: load_ready=1, sout_valid=0, sout=0. On accept -> SHIFT, bit_cnt=0.
  - SHIFT: sout_valid=1 and sout = current bit, selected by MSB_FIRST.
    - shift_reg shifts one position per cycle; bit_cnt increments 0..WIDTH-1.
    - frame_start=1 when bit_cnt=0; frame_end=1 when bit_cnt=WIDTH-1; both are 0 otherwise.
  - Leaving SHIFT at bit_cnt=WIDTH-1:
    - GAP>0: -> GAP, gap_cnt=0.
    - GAP=0 and a load is accepted this cycle: stay in SHIFT, reload, bit_cnt=0. The next frame's first bit follows with no bubble.
    - GAP=0 and no load: -> IDLE.
  - GAP: sout_valid=0, sout=0, load_ready=0. After exactly GAP cycles -> IDLE.
- load_ready is a combinational decode of state: 1 in IDLE, or in SHIFT at bit_cnt=WIDTH-1 when GAP=0; 0 otherwise. It has no combinational path from load_valid.
- busy = (state != IDLE).
- WIDTH=2: frame_start and frame_end are on consecutive cycles and never coincide.
- Reset mid-frame: the frame aborts immediately. No frame_end is issued for the partial word. The remaining bits are discarded and the block restarts in IDLE.
- Counters: bit_cnt is $clog2(WIDTH) bits and gap_cnt is 4 bits. Neither counter wraps outside its defined range.

Test Plan:
1. Defaults, load 4'b1011 at T0 -> sout=1,0,1,1 on T1..T4; sout_valid=1 on T1..T4; frame_start on T1; frame_end on T4; load_ready=0 on T1..T3, back to 1 on T4; busy=0 from T5.
2. Back-to-back: 4'b1011 then 4'b0110 with load_valid held high -> 8 consecutive valid bits 1,0,1,1,0,1,1,0; frame_start on T1 and T5; frame_end on T4 and T8; no idle cycle between frames.
3. MSB_FIRST=0, load 4'b1011 -> sout=1,1,0,1; frame strobes on the same cycles as scenario 1.
4. GAP=2, two back-to-back requests -> first frame on T1..T4; sout_valid=0 and load_ready=0 on T5..T6; second word accepted at T7 and its first bit on T8.
5. rst pulled low during T2 of a 4'b1011 frame -> sout, sout_valid and busy drop to 0 immediately with no frame_end; load_ready=1. After release, a load of 4'b0001 serializes cleanly as 0,0,0,1.
6. Word 4'b1111 accepted at T0, then load_data changed to 4'b0000 with load_valid=1 during T1..T3 -> output stays 1,1,1,1; 4'b0000 is accepted at T4 and its bits appear on T5..T8.
